// File: rtl/tia_d1_chain.sv
// Multi-stage, multi-bit TIA D1 delay line with an internal non-overlapping
// two-phase sequencer (IDLE -> PH1 -> GAP1 -> PH2 -> GAP2).
module tia_d1_chain #(
  parameter int WIDTH     = 1,
  parameter int DEPTH     = 4,
  parameter bit PRECHARGE = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   shift_en,
  input  logic                   run,
  input  logic [WIDTH-1:0]       in,
  output logic                   s1,
  output logic                   s2,
  output logic                   busy,
  output logic                   done,
  output logic [DEPTH*WIDTH-1:0] tap,
  output logic [WIDTH-1:0]       out
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH1  = 3'd1,
    GAP1 = 3'd2,
    PH2  = 3'd3,
    GAP2 = 3'd4
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [DEPTH*WIDTH-1:0] store;
  logic [DEPTH*WIDTH-1:0] d;
  logic [WIDTH-1:0]       last;

  // Stage inputs: stage 0 takes the chain input, stage k takes the old store of k-1.
  generate
    if (DEPTH == 1) begin : g_single
      assign d = in;
    end else begin : g_multi
      assign d = {store[(DEPTH-1)*WIDTH-1:0], in};
    end
  endgenerate

  assign last = store[(DEPTH-1)*WIDTH +: WIDTH];

  // Sequencer state plus tap (inverting, phase 1) and store (phase 2) registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tap   <= {(DEPTH*WIDTH){1'b1}};
      store <= {(DEPTH*WIDTH){1'b0}};
    end else begin
      state <= next_state;
      if (state == PH1) begin
        tap <= ~d;
      end
      if (state == GAP1) begin
        store <= ~tap;
      end
    end
  end

  // Next-state logic; a request seen outside IDLE is dropped, not queued.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE: begin
        if (shift_en || run) begin
          next_state = PH1;
        end else begin
          next_state = IDLE;
        end
      end
      PH1:  next_state = GAP1;
      GAP1: next_state = PH2;
      PH2:  next_state = GAP2;
      GAP2: begin
        if (run) begin
          next_state = PH1;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign s1   = (state == PH1);
  assign s2   = (state == PH2);
  assign busy = (state != IDLE);
  assign done = (state == GAP2);

  // Output gating: with precharge the line idles high except while phase 2 is active.
  always_comb begin
    out = last;
    if (PRECHARGE) begin
      if (state == PH2) begin
        out = last;
      end else begin
        out = {WIDTH{1'b1}};
      end
    end else begin
      out = last;
    end
  end

endmodule

// File: tb/tb_tia_d1_chain.sv
// Self-checking bench: three configurations of tia_d1_chain share the control inputs
// and are compared each cycle against a shift-history reference model.
module tb_tia_d1_chain;

  logic        clk = 1'b0;
  logic        reset;
  logic        shift_en;
  logic        run;
  logic [7:0]  in_a, in_b;
  logic [0:0]  in_c;

  logic        s1_a, s2_a, busy_a, done_a;
  logic        s1_b, s2_b, busy_b, done_b;
  logic        s1_c, s2_c, busy_c, done_c;
  logic [31:0] tap_a;
  logic [15:0] tap_b;
  logic [0:0]  tap_c;
  logic [7:0]  out_a, out_b;
  logic [0:0]  out_c;

  int checks = 0;
  int errors = 0;

  // Reference model: phase index (0 idle,1 PH1,2 GAP1,3 PH2,4 GAP2),
  // values sampled per shift since reset, and counts of shifts tapped/stored.
  int          ph = 0;
  int          n_tap = 0;
  int          n_store = 0;
  int          seq;
  logic [7:0]  hist_a[$];
  logic [7:0]  hist_b[$];
  logic [0:0]  hist_c[$];

  always #5 clk = ~clk;

  tia_d1_chain #(.WIDTH(8), .DEPTH(4), .PRECHARGE(1'b1)) u_a (
    .clk(clk), .reset(reset), .shift_en(shift_en), .run(run), .in(in_a),
    .s1(s1_a), .s2(s2_a), .busy(busy_a), .done(done_a), .tap(tap_a), .out(out_a));

  tia_d1_chain #(.WIDTH(8), .DEPTH(2), .PRECHARGE(1'b0)) u_b (
    .clk(clk), .reset(reset), .shift_en(shift_en), .run(run), .in(in_b),
    .s1(s1_b), .s2(s2_b), .busy(busy_b), .done(done_b), .tap(tap_b), .out(out_b));

  tia_d1_chain #(.WIDTH(1), .DEPTH(1), .PRECHARGE(1'b1)) u_c (
    .clk(clk), .reset(reset), .shift_en(shift_en), .run(run), .in(in_c),
    .s1(s1_c), .s2(s2_c), .busy(busy_c), .done(done_c), .tap(tap_c), .out(out_c));

  function automatic logic [7:0] val_a(int i);
    return (i >= 0 && i < hist_a.size()) ? hist_a[i] : 8'h00;
  endfunction
  function automatic logic [7:0] val_b(int i);
    return (i >= 0 && i < hist_b.size()) ? hist_b[i] : 8'h00;
  endfunction
  function automatic logic [0:0] val_c(int i);
    return (i >= 0 && i < hist_c.size()) ? hist_c[i] : 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] etap;
    logic [7:0]  sa, sb;
    logic [0:0]  sc;
    for (int k = 0; k < 4; k++) etap[k*8 +: 8] = ~val_a(n_tap - 1 - k);
    sa = val_a(n_store - 4);
    sb = val_b(n_store - 2);
    sc = val_c(n_store - 1);
    chk("s1",    {31'd0, s1_a},   {31'd0, ph == 1});
    chk("s2",    {31'd0, s2_a},   {31'd0, ph == 3});
    chk("busy",  {31'd0, busy_a}, {31'd0, ph != 0});
    chk("done",  {31'd0, done_a}, {31'd0, ph == 4});
    chk("ctl_b", {28'd0, s1_b, s2_b, busy_b, done_b}, {28'd0, s1_a, s2_a, busy_a, done_a});
    chk("ctl_c", {28'd0, s1_c, s2_c, busy_c, done_c}, {28'd0, ph == 1, ph == 3, ph != 0, ph == 4});
    chk("tap_a", tap_a, etap);
    chk("tap_c", {31'd0, tap_c}, {31'd0, ~val_c(n_tap - 1)});
    chk("out_a", {24'd0, out_a}, {24'd0, (ph == 3) ? sa : 8'hFF});
    chk("out_b", {24'd0, out_b}, {24'd0, sb});
    chk("out_c", {31'd0, out_c}, {31'd0, (ph == 3) ? sc : 1'b1});
  endtask

  // One clock: predict from pre-edge inputs, wait for the edge, then compare.
  task automatic tick();
    int nph;
    logic rs, go, rn;
    logic [7:0] ia, ib;
    logic [0:0] ic;
    rs = reset; go = shift_en; rn = run; ia = in_a; ib = in_b; ic = in_c;
    @(posedge clk);
    #1;
    if (rs) begin
      nph = 0; n_tap = 0; n_store = 0;
      hist_a.delete(); hist_b.delete(); hist_c.delete();
    end else begin
      case (ph)
        0: nph = (go || rn) ? 1 : 0;
        1: begin nph = 2; n_tap++; hist_a.push_back(ia); hist_b.push_back(ib); hist_c.push_back(ic); end
        2: begin nph = 3; n_store++; end
        3: nph = 4;
        default: nph = rn ? 1 : 0;
      endcase
    end
    ph = nph;
    check_all();
  endtask

  initial begin
    reset = 1'b1; shift_en = 1'b1; run = 1'b0;
    in_a = 8'h5A; in_b = 8'hC3; in_c = 1'b1;
    // Reset held two clocks, with a shift request that must be ignored.
    tick(); tick();
    reset = 1'b0; shift_en = 1'b0;

    // Single shifts: in_c=1 then in_c=0.
    for (int r = 0; r < 2; r++) begin
      in_c = (r == 0) ? 1'b1 : 1'b0;
      in_a = 8'($urandom); in_b = 8'($urandom);
      shift_en = 1'b1; tick(); shift_en = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("single_idle", {31'd0, busy_c}, 32'd0);
    end

    // Request during GAP1 of an active shift is dropped.
    shift_en = 1'b1; tick(); shift_en = 1'b0; tick();
    shift_en = 1'b1; tick(); shift_en = 1'b0;
    tick(); tick();
    chk("drop_idle", {31'd0, busy_a}, 32'd0);
    tick();
    chk("drop_stay_idle", {31'd0, busy_a}, 32'd0);

    // Continuous run with an incrementing sequence on in_a.
    seq = 1; in_a = 8'(seq); run = 1'b1;
    for (int i = 0; i < 48; i++) begin
      in_b = 8'($urandom); in_c = 1'($urandom);
      tick();
      if (ph == 2) begin seq++; in_a = 8'(seq); end
    end
    run = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("run_stop_idle", {31'd0, busy_a}, 32'd0);

    // Randomized control and data, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 49) == 0);
      shift_en = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) run = ~run;
      in_a = 8'($urandom); in_b = 8'($urandom); in_c = 1'($urandom);
      tick();
    end
    reset = 1'b0; shift_en = 1'b0; run = 1'b1;

    // Reset asserted during PH2 with loaded stages, then a clean restart.
    for (int i = 0; i < 12 && ph != 3; i++) tick();
    chk("reach_ph2", {31'd0, s2_a}, 32'd1);
    run = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_tap", tap_a, 32'hFFFF_FFFF);
    chk("rst_out", {24'd0, out_a}, 32'h0000_00FF);
    in_a = 8'h3C; in_b = 8'hA5; in_c = 1'b1;
    shift_en = 1'b1; tick(); shift_en = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
